// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
//   state_e      debounce FSM states
//   scan_res_e   classification of one full four-column scan
//   COL_INIT     column drive after reset (column 0 driven low)
//   COL_LAST     column drive during the last dwell of a scan
//   low_index    position of the lowest-numbered 0 bit in an active-low nibble
//   low_count    number of 0 bits in an active-low nibble
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_e;

  typedef enum logic [1:0] {SCAN_NONE, SCAN_KEY, SCAN_MULTI} scan_res_e;

  localparam logic [3:0] COL_INIT = 4'b1110;
  localparam logic [3:0] COL_LAST = 4'b0111;

  function automatic logic [1:0] low_index(input logic [3:0] v_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] v_n);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!v_n[i]) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running divider that emits a one-cycle tick every DIV
// clock cycles (at the terminal count DIV-1). Shared with display multiplexing.
//   clk    in   system clock
//   reset  in   synchronous active-high reset (count returns to 0)
//   tick   out  high for one cycle when the count is DIV-1
module scan_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          tick_c;

  always_comb begin
    tick_c  = (count_q == TERM);
    count_d = tick_c ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign tick = tick_c;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and reports one
// debounced key code per press.
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   row[3:0]   in   keypad rows, active-low, asynchronous to clk
//   col[3:0]   out  column drive, active-low, exactly one bit low
//   key_code   out  row_idx*4 + col_idx of the last accepted key (held)
//   key_valid  out  one-cycle pulse when a key is accepted; there is no
//                   back-pressure: the consumer must take key_code in the
//                   cycle key_valid is high
//   key_held   out  high from acceptance until the release is debounced
//   state_dbg  out  current debounce FSM state
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output state_e     state_dbg
);

  localparam int unsigned DWELL = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

  logic tick;

  scan_tick_gen #(.DIV(DWELL)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  logic [3:0]       row_meta_q, row_meta_d;
  logic [3:0]       row_sync_q, row_sync_d;
  logic [3:0]       col_q, col_d;
  // acc_n counts low row bits seen so far in this scan, saturating at 2 ("many").
  logic [1:0]       acc_n_q, acc_n_d;
  logic [3:0]       acc_code_q, acc_code_d;
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic [2:0]       sample_n;
  logic [2:0]       total;
  logic [1:0]       acc_n_nx;
  logic [3:0]       acc_code_nx;
  logic             scan_done;
  scan_res_e        scan_res;

  always_comb begin
    row_meta_d  = row;
    row_sync_d  = row_meta_q;
    col_d       = col_q;
    acc_n_d     = acc_n_q;
    acc_code_d  = acc_code_q;
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    scan_done   = 1'b0;
    scan_res    = SCAN_NONE;

    // Fold the current column's sample into the per-scan accumulator.
    sample_n    = low_count(row_sync_q);
    total       = {1'b0, acc_n_q} + sample_n;
    acc_n_nx    = (total > 3'd2) ? 2'd2 : total[1:0];
    acc_code_nx = acc_code_q;
    if (acc_n_q == 2'd0 && sample_n == 3'd1) begin
      acc_code_nx = {low_index(row_sync_q), low_index(col_q)};
    end

    if (tick) begin
      col_d      = {col_q[2:0], col_q[3]};
      acc_n_d    = acc_n_nx;
      acc_code_d = acc_code_nx;
      if (col_q == COL_LAST) begin
        scan_done = 1'b1;
        acc_n_d   = 2'd0;
        case (acc_n_nx)
          2'd0:    scan_res = SCAN_NONE;
          2'd1:    scan_res = SCAN_KEY;
          default: scan_res = SCAN_MULTI;
        endcase
      end
    end

    if (scan_done) begin
      case (state_q)
        IDLE: begin
          if (scan_res == SCAN_KEY) begin
            cand_d  = acc_code_nx;
            cnt_d   = CNT_ONE;
            state_d = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (scan_res == SCAN_KEY) begin
            if (acc_code_nx == cand_q) begin
              if (cnt_q != CNT_TARGET) cnt_d = cnt_q + 1'b1;
            end else begin
              cand_d = acc_code_nx;
              cnt_d  = CNT_ONE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          // Any key activity (including a second key) keeps the press alive.
          if (scan_res == SCAN_NONE) begin
            cnt_d   = CNT_ONE;
            state_d = REL_DB;
          end
        end
        REL_DB: begin
          if (scan_res == SCAN_NONE) begin
            if (cnt_q != CNT_TARGET) cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase

      // Threshold tests use the updated count so a target of 1 accepts on
      // the very first matching scan.
      if (state_d == PRESS_DB && cnt_d == CNT_TARGET) begin
        key_code_d  = cand_d;
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
        state_d     = PRESSED;
      end else if (state_d == REL_DB && cnt_d == CNT_TARGET) begin
        key_held_d = 1'b0;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q  <= 4'b1111;
      row_sync_q  <= 4'b1111;
      col_q       <= COL_INIT;
      acc_n_q     <= 2'd0;
      acc_code_q  <= 4'd0;
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      col_q       <= col_d;
      acc_n_q     <= acc_n_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model + per-scan reference model feeding a
// scoreboard; a monitor checks col rotation, key_valid pulses, key_code and
// key_held against the expectations.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int DB    = 3;
  localparam int DWELL = 4;
  localparam int SCAN  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  state_e     state_dbg;

  logic [15:0] pressed;

  int checks   = 0;
  int failures = 0;

  // {due cycle[15:0], key code[3:0]}
  logic [19:0] exp_q[$];
  logic        held_q[$];

  int   cyc;
  logic prev_valid;
  logic [3:0] last_code;

  // reference model state: result of the previous scan and its run length
  int last_res;
  int run_len;
  bit m_held;
  int scan_idx;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  keypad_scanner #(
    .CLK_HZ         (16),
    .SCAN_HZ        (4),
    .DEBOUNCE_SCANS (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .state_dbg (state_dbg)
  );

  // keypad matrix: a pressed key shorts its row to its (low) column
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    last_res = -3;
    run_len  = 0;
    m_held   = 1'b0;
    scan_idx = 0;
  endtask

  // One full scan with a constant set of pressed keys.
  task automatic model_scan(input logic [15:0] m);
    int res;
    int n;
    n = $countones(m);
    if (n == 0)     res = -1;
    else if (n > 1) res = -2;
    else begin
      res = 0;
      for (int k = 0; k < 16; k++) if (m[k]) res = k;
    end
    if (res == last_res) run_len++;
    else begin
      run_len  = 1;
      last_res = res;
    end
    if (!m_held && res >= 0 && run_len == DB) begin
      m_held = 1'b1;
      exp_q.push_back({16'(scan_idx*SCAN + SCAN - 1), 4'(res)});
    end else if (m_held && res == -1 && run_len == DB) begin
      m_held = 1'b0;
    end
    held_q.push_back(m_held);
    scan_idx++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_scan(input logic [15:0] m);
    pressed = m;
    model_scan(m);
    repeat (SCAN) @(negedge clk);
  endtask

  task automatic do_reset(input logic [15:0] m);
    pressed = m;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    check("queues_drained_at_reset", exp_q.size() + held_q.size(), 0);
    exp_q.delete();
    held_q.delete();
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [3:0]  exp_col;
    logic [19:0] e;
    #1;
    if (reset) begin
      cyc        = 0;
      prev_valid = 1'b0;
      last_code  = 4'd0;
      check("rst_col", col, 4'b1110);
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_key_held", key_held, 1'b0);
      check("rst_key_code", key_code, 4'd0);
    end else begin
      exp_col = ~(4'b0001 << (((cyc + 1) / DWELL) % 4));
      check("col_rotation", col, exp_col);
      if (exp_q.size() > 0 && cyc > int'(exp_q[0][19:4])) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_key_valid: no pulse by cycle %0d, required code %0d at cycle %0d",
                 cyc, e[3:0], e[19:4]);
      end
      if (key_valid) begin
        check("key_valid_back_to_back", prev_valid, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_key_valid: got pulse with code %0d at cycle %0d, required none",
                   key_code, cyc);
        end else begin
          e = exp_q.pop_front();
          last_code = e[3:0];
          check("key_code", key_code, e[3:0]);
          check("key_valid_cycle", cyc, e[19:4]);
        end
      end
      if (cyc % SCAN == SCAN - 1) begin
        if (held_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL held_queue_empty: scan end at cycle %0d with no expectation", cyc);
        end else begin
          check("key_held", key_held, held_q.pop_front());
        end
        check("key_code_hold", key_code, last_code);
      end
      prev_valid = key_valid;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] m;
    int sel;
    int len;
    reset   = 1'b1;
    pressed = 16'h0;
    model_reset();
    do_reset(16'h0);

    repeat (4) run_scan(16'h0);                       // idle: no pulses

    repeat (6) run_scan(16'h0200);                    // key 9 = (2,1)
    repeat (5) run_scan(16'h0);

    for (int i = 0; i < 5; i++) run_scan((i % 2 == 0) ? 16'h0080 : 16'h0000);  // bounce key 7
    repeat (4) run_scan(16'h0080);
    repeat (5) run_scan(16'h0);

    repeat (5) run_scan(16'h8001);                    // ghost: (0,0)+(3,3)
    repeat (3) run_scan(16'h0);

    repeat (4) run_scan(16'h0001);                    // rollover: 0 then add 15
    repeat (3) run_scan(16'h8001);
    repeat (2) run_scan(16'h8000);
    repeat (5) run_scan(16'h0);

    repeat (5) run_scan(16'h0020);                    // key 5, reset while held
    do_reset(16'h0020);
    repeat (5) run_scan(16'h0020);
    repeat (5) run_scan(16'h0);

    for (int i = 0; i < 25; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3)      m = 16'h0;
      else if (sel < 8) m = 16'h1 << $urandom_range(0, 15);
      else              m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      len = $urandom_range(1, 5);
      repeat (len) run_scan(m);
    end
    repeat (5) run_scan(16'h0);

    check("exp_queue_drained", exp_q.size(), 0);
    check("held_queue_drained", held_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and produces debounced key codes, one event per key press.
- Input-side counterpart of the multiplexed 7-segment display path: the display writes a scanned, active-low select bus; this block drives the column selects and reads back the rows.
- Its output feeds the BCD counter/display logic for preset and entry.
- Runs on the 100 MHz system clock.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- SCAN_HZ, 1000, column step rate (one column dwell = CLK_HZ/SCAN_HZ cycles).
- DEBOUNCE_SCANS, 4, number of consecutive identical full scans (4 dwells each) needed to accept a press or a release.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- row  input  4  keypad rows; active-low, pulled up externally; asynchronous to clk.
- col  output  4  column drive; active-low, exactly one bit low at any time.
- key_code  output  4  code of the accepted key = row_idx*4 + col_idx; held until the next accepted press.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_held  output  1  high while the accepted key remains pressed (until release is debounced).

Behaviour:
- Reset (synchronous, active-high; clock and reset fixed as one clk, reset):
  - col=4'b1110, key_code=0, key_valid=0, key_held=0.
  - FSM=IDLE; all counters and synchronizers cleared to 0 (row synchronizer cleared to 4'b1111).
  - Reset asserted mid-press returns to IDLE with no key_valid pulse. A key still held after reset is re-debounced and reported.
- Row synchronizer: 2 flops. All sampling uses the synchronized value.
- Tick: divider counts 0..CLK_HZ/SCAN_HZ-1 and pulses tick for one cycle at the terminal count.
- Column rotation: on each tick, sample the synchronized row for the current column, then rotate col 1110 -> 1101 -> 1011 -> 0111 -> 1110. col_idx is the position of the low bit.
- Scan result is evaluated after the sample taken at col=0111, i.e. once per full scan:
  - NONE: no low row bits in any of the 4 samples.
  - KEY(k): exactly one low bit across all 4 samples.
  - MULTI: more than one low bit. MULTI is treated as NONE for press acceptance and as "not released" for release (ghost protection).
- FSM, evaluated once per full scan; cnt counts matching scans:
  - IDLE: on KEY(k), cand=k, cnt=1, go to PRESS_DB. Otherwise stay.
  - PRESS_DB:
    - KEY(cand): cnt++. When cnt reaches DEBOUNCE_SCANS: key_code=cand, key_valid pulses in the same clk cycle, key_held=1, go to PRESSED.
    - KEY(other): cand=other, cnt=1.
    - NONE/MULTI: go to IDLE.
  - PRESSED:
    - NONE: cnt=1, go to REL_DB.
    - Anything else stays in PRESSED; a different key is ignored (no rollover).
  - REL_DB:
    - NONE: cnt++. When cnt reaches DEBOUNCE_SCANS: key_held=0, go to IDLE.
    - Any non-NONE result: return to PRESSED with no new key_valid.
- Latency from a stable press to key_valid: between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 full scans, plus 2 cycles of synchronizer delay.
- key_valid never asserts on two consecutive cycles. There is at most one pulse per press/release cycle.
- With DEBOUNCE_SCANS=1, a key is accepted on the first matching scan.
- Divider width = clog2(CLK_HZ/SCAN_HZ). cnt width = clog2(DEBOUNCE_SCANS+1). cnt saturates, never wraps.

Decomposition:
- Package keypad_pkg:
  - state enum {IDLE, PRESS_DB, PRESSED, REL_DB}.
  - scan-result encoding {NONE, KEY, MULTI}.
  - COL_INIT=4'b1110.
  - Optional 16-entry constant mapping code to the printed hex legend, for the display path.
- One sub-module: scan_tick_gen (parameterised divider emitting the one-cycle tick), reusable for display multiplexing.

Test Plan:
- Bench parameters: CLK_HZ=16, SCAN_HZ=4 (4-cycle dwell, 16-cycle scan), DEBOUNCE_SCANS=3. Keypad model pulls row[r] low whenever col[c] is low and key (r,c) is pressed.
- Reset: hold reset 3 cycles -> col=1110, key_valid=0, key_held=0, key_code=0. Release with no key -> col cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts.
- Press (row 2, col 1) held for 6 scans -> exactly one key_valid pulse with key_code=4'd9, within 3-4 scans (+2 cycles). key_held=1 until 3 scans after release, then 0.
- Bounce: toggle (1,3) on/off every scan for 5 scans, then hold steady -> no pulse during bouncing. A single pulse with key_code=4'd7 after 3 stable scans.
- Ghost/rollover:
  - Press (0,0) and (3,3) together -> no pulse.
  - Press (0,0), then add (3,3) after acceptance -> one pulse, code 0. key_held stays 1 until both keys are released and 3 NONE scans have elapsed.
- Reset mid-operation: assert reset while in PRESSED with key 5 held, then deassert -> outputs clear immediately. Key re-accepted after the debounce time with exactly one new pulse, code 5.
